// File: rtl/memreg_pkg.sv
// Shared pipeline and data-bus types for the memory-stage register.
// Bus types live in common; pipeline entry and the register's FSM state live in pipes.
package common;

   typedef struct packed {
      logic        valid;
      logic [63:0] addr;
      logic [2:0]  size;
      logic [7:0]  strobe;
      logic [63:0] data;
   } dbus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [63:0] data;
   } dbus_resp_t;

endpackage

package pipes;

   typedef struct packed {
      logic        valid;
      logic [63:0] pc;
      logic [1:0]  memRw;
      logic [63:0] result;
      logic [4:0]  rd;
   } execute_data_t;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_DATA = 2'd1,
      HOLD      = 2'd2
   } memreg_state_t;

endpackage

// File: rtl/memreg_if.sv
// Data-bus connection between the memory-stage register and the bus.
interface memreg_if;
   common::dbus_req_t  dreq;
   common::dbus_resp_t dresp;

   modport master (output dreq, input dresp);
   modport slave  (input dreq, output dresp);
endinterface

// File: rtl/memreg.sv
// Execute->memory pipeline register that owns the data-bus access of its entry:
// issues the request once, stalls until data returns, and holds the data while frozen.
module memreg
   import common::*, pipes::*;
(
   input  logic          clk,
   input  logic          reset,
   input  execute_data_t dataE_nxt,
   input  logic          stall_ext,
   input  logic          flush,
   output execute_data_t dataE,
   input  dbus_req_t     dreq_in,
   memreg_if.master      dbus,
   output dbus_resp_t    dresp_o,
   output logic          mem_stall
);

   memreg_state_t state;
   logic [63:0]   held;
   logic          flush_pending;

   logic req, complete, advance, bubble, load;

   always_comb begin
      req       = dataE.valid && dreq_in.valid;
      dbus.dreq = '0;
      dresp_o   = req ? dbus.dresp : '0;
      complete  = 1'b0;
      mem_stall = 1'b0;
      unique case (state)
         IDLE: begin
            if (req) dbus.dreq = dreq_in;
            complete  = req && dbus.dresp.data_ok;
            mem_stall = req && !dbus.dresp.data_ok;
         end
         WAIT_DATA: begin
            // address already accepted: keep the request on the bus until data returns
            dbus.dreq       = dreq_in;
            dbus.dreq.valid = 1'b1;
            complete        = dbus.dresp.data_ok;
            mem_stall       = !dbus.dresp.data_ok;
         end
         HOLD: begin
            dresp_o         = '0;
            dresp_o.data_ok = 1'b1;
            dresp_o.data    = held;
         end
         default: ;
      endcase
      advance = !mem_stall && !stall_ext;
      // a direct flush beats stall_ext; a deferred flush waits for a normal advance
      bubble  = !mem_stall && (flush || (flush_pending && !stall_ext));
      load    = advance || bubble;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         dataE         <= '0;
         held          <= '0;
         flush_pending <= 1'b0;
      end else begin
         if (bubble)       dataE <= '0;
         else if (advance) dataE <= dataE_nxt;

         if (load)                    flush_pending <= 1'b0;
         else if (flush && mem_stall) flush_pending <= 1'b1;

         if (complete) held <= dbus.dresp.data;

         unique case (state)
            IDLE: begin
               if (complete)                        state <= load ? IDLE : HOLD;
               else if (req && dbus.dresp.addr_ok)  state <= WAIT_DATA;
            end
            WAIT_DATA: if (complete) state <= load ? IDLE : HOLD;
            HOLD:      if (load)     state <= IDLE;
            default:   state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_memreg.sv
// Self-checking bench for memreg: directed scenarios plus a randomized run
// against a flag-based model of the access/stall/flush rules.
module tb_memreg;
   import common::*, pipes::*;

   logic          clk = 1'b0;
   logic          reset;
   execute_data_t dataE_nxt, dataE;
   logic          stall_ext, flush, mem_stall;
   dbus_req_t     dreq_in;
   dbus_resp_t    dresp_o;
   int            errors = 0;
   int            checks = 0;

   memreg_if bus ();

   memreg dut (
      .clk       (clk),
      .reset     (reset),
      .dataE_nxt (dataE_nxt),
      .stall_ext (stall_ext),
      .flush     (flush),
      .dataE     (dataE),
      .dreq_in   (dreq_in),
      .dbus      (bus),
      .dresp_o   (dresp_o),
      .mem_stall (mem_stall)
   );

   always #5 clk = ~clk;

   function automatic execute_data_t mk(input logic [63:0] pc, input logic [1:0] rw,
                                        input logic [63:0] addr);
      execute_data_t e;
      e        = '0;
      e.valid  = 1'b1;
      e.pc     = pc;
      e.memRw  = rw;
      e.result = addr;
      e.rd     = pc[6:2];
      return e;
   endfunction

   // what the memory stage would present for a given entry
   function automatic dbus_req_t to_req(input execute_data_t e);
      dbus_req_t r;
      r        = '0;
      r.valid  = (e.memRw != 2'b00);
      r.addr   = e.result;
      r.size   = 3'd3;
      r.strobe = (e.memRw == 2'b10) ? 8'hff : 8'h00;
      r.data   = e.pc ^ 64'h5a5a_5a5a_5a5a_5a5a;
      return r;
   endfunction

   function automatic dbus_resp_t resp(input logic a, input logic d, input logic [63:0] data);
      dbus_resp_t r;
      r.addr_ok = a;
      r.data_ok = d;
      r.data    = data;
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_entry(input execute_data_t e);
      dataE_nxt = e;
      dreq_in   = '0;
      bus.dresp = '0;
      stall_ext = 1'b0;
      flush     = 1'b0;
      tick();
      dreq_in = to_req(e);
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      stall_ext = 1'b0;
      flush     = 1'b0;
      dataE_nxt = mk(64'h10, 2'b01, 64'h8000_0000);
      dreq_in   = to_req(dataE_nxt);
      bus.dresp = resp(1'b1, 1'b1, 64'hdead_beef_0000_0001);
      repeat (2) tick();
      checks++; if (dataE !== '0) begin errors++; $display("FAIL reset_dataE: got %h want 0", dataE); end
      checks++; if (bus.dreq.valid !== 1'b0) begin errors++; $display("FAIL reset_dreq_valid: got %b want 0", bus.dreq.valid); end
      checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", mem_stall); end
      checks++; if (dresp_o !== '0) begin errors++; $display("FAIL reset_dresp_o: got %h want 0", dresp_o); end
      reset = 1'b0;
      #1;
      checks++; if (bus.dreq.valid !== 1'b0 || mem_stall !== 1'b0) begin
         errors++; $display("FAIL post_reset: dreq.valid=%b stall=%b want 0 0", bus.dreq.valid, mem_stall); end
   endtask

   task automatic test_fast_load();
      execute_data_t e, n;
      e = mk(64'h100, 2'b01, 64'h8000_0010);
      n = mk(64'h104, 2'b00, 64'h0);
      load_entry(e);
      dataE_nxt = n;
      bus.dresp = resp(1'b1, 1'b1, 64'h1122_3344_5566_7788);
      #1;
      checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL fast_stall: got %b want 0", mem_stall); end
      checks++; if (dresp_o.data !== 64'h1122_3344_5566_7788 || dresp_o.data_ok !== 1'b1) begin
         errors++; $display("FAIL fast_data: got %h want 1122334455667788", dresp_o.data); end
      checks++; if (bus.dreq !== to_req(e)) begin errors++; $display("FAIL fast_dreq: got %h want %h", bus.dreq, to_req(e)); end
      tick();
      dreq_in   = to_req(n);
      bus.dresp = '0;
      #1;
      checks++; if (dataE !== n) begin errors++; $display("FAIL fast_advance: got %h want %h", dataE, n); end
      checks++; if (bus.dreq.valid !== 1'b0) begin errors++; $display("FAIL fast_no_reissue: got %b want 0", bus.dreq.valid); end
   endtask

   task automatic test_slow_load();
      execute_data_t e, n;
      logic [63:0]   d;
      e = mk(64'h200, 2'b01, 64'h8000_0018);
      n = mk(64'h204, 2'b00, 64'h0);
      d = 64'h0bad_cafe_0123_4567;
      load_entry(e);
      dataE_nxt = n;
      for (int c = 0; c <= 4; c++) begin
         bus.dresp = resp(c == 1, c == 4, (c == 4) ? d : {$urandom, $urandom});
         #1;
         checks++; if (mem_stall !== (c < 4)) begin errors++; $display("FAIL slow_stall_c%0d: got %b want %b", c, mem_stall, c < 4); end
         checks++; if (bus.dreq !== to_req(e)) begin errors++; $display("FAIL slow_dreq_c%0d: got %h want %h", c, bus.dreq, to_req(e)); end
         if (c == 4) begin
            checks++; if (dresp_o.data !== d) begin errors++; $display("FAIL slow_data: got %h want %h", dresp_o.data, d); end
         end
         tick();
         checks++; if (dataE !== ((c < 4) ? e : n)) begin errors++; $display("FAIL slow_dataE_c%0d: got %h", c, dataE); end
      end
      dreq_in   = to_req(n);
      bus.dresp = '0;
      #1;
      checks++; if (bus.dreq.valid !== 1'b0) begin errors++; $display("FAIL slow_single_access: got %b want 0", bus.dreq.valid); end
   endtask

   task automatic test_hold();
      execute_data_t e, n;
      logic [63:0]   d;
      e = mk(64'h300, 2'b01, 64'h8000_0040);
      n = mk(64'h304, 2'b00, 64'h0);
      d = 64'hcafe_f00d_1234_5678;
      load_entry(e);
      dataE_nxt = n;
      stall_ext = 1'b1;
      bus.dresp = resp(1'b1, 1'b1, d);
      #1;
      checks++; if (mem_stall !== 1'b0 || dresp_o.data !== d) begin
         errors++; $display("FAIL hold_complete: stall=%b data=%h want 0 %h", mem_stall, dresp_o.data, d); end
      for (int c = 1; c <= 3; c++) begin
         tick();
         checks++; if (dataE !== e) begin errors++; $display("FAIL hold_frozen_c%0d: got %h want %h", c, dataE, e); end
         stall_ext = (c < 3);
         bus.dresp = resp(1'b0, 1'b0, {$urandom, $urandom});
         #1;
         checks++; if (bus.dreq.valid !== 1'b0) begin errors++; $display("FAIL hold_dreq_c%0d: got %b want 0", c, bus.dreq.valid); end
         checks++; if (dresp_o !== resp(1'b0, 1'b1, d)) begin errors++; $display("FAIL hold_dresp_c%0d: got %h want data_ok with %h", c, dresp_o, d); end
         checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL hold_stall_c%0d: got %b want 0", c, mem_stall); end
      end
      tick();
      dreq_in = to_req(n);
      #1;
      checks++; if (dataE !== n) begin errors++; $display("FAIL hold_advance: got %h want %h", dataE, n); end
      checks++; if (dresp_o !== '0) begin errors++; $display("FAIL hold_exit_dresp: got %h want 0", dresp_o); end
   endtask

   task automatic test_flush_wait();
      execute_data_t e, n;
      logic [63:0]   d;
      e = mk(64'h400, 2'b10, 64'h8000_0080);
      n = mk(64'h404, 2'b00, 64'h77);
      d = 64'h5555_aaaa_3333_cccc;
      load_entry(e);
      dataE_nxt = n;
      bus.dresp = resp(1'b1, 1'b0, 64'h0);
      #1;
      checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL flush_stall0: got %b want 1", mem_stall); end
      tick();
      flush     = 1'b1;
      bus.dresp = '0;
      #1;
      checks++; if (mem_stall !== 1'b1 || bus.dreq !== to_req(e)) begin
         errors++; $display("FAIL flush_wait: stall=%b dreq=%h", mem_stall, bus.dreq); end
      tick();
      checks++; if (dataE !== e) begin errors++; $display("FAIL flush_kept: got %h want %h", dataE, e); end
      flush     = 1'b0;
      bus.dresp = resp(1'b0, 1'b1, d);
      #1;
      checks++; if (mem_stall !== 1'b0 || dresp_o.data !== d) begin
         errors++; $display("FAIL flush_complete: stall=%b data=%h want 0 %h", mem_stall, dresp_o.data, d); end
      tick();
      dreq_in   = '0;
      bus.dresp = '0;
      #1;
      checks++; if (dataE !== '0) begin errors++; $display("FAIL flush_bubble: got %h want 0", dataE); end
      tick();
      dreq_in = to_req(n);
      checks++; if (dataE !== n) begin errors++; $display("FAIL flush_pending_clear: got %h want %h", dataE, n); end
   endtask

   task automatic test_reset_mid();
      execute_data_t e, f, n;
      e = mk(64'h500, 2'b01, 64'h8000_0090);
      f = mk(64'h600, 2'b01, 64'h8000_0020);
      n = mk(64'h604, 2'b00, 64'h0);
      load_entry(e);
      bus.dresp = resp(1'b1, 1'b0, 64'h0);
      tick();
      bus.dresp = '0;
      reset     = 1'b1;
      #1;
      checks++; if (dataE.valid !== 1'b0 || bus.dreq.valid !== 1'b0 || mem_stall !== 1'b0) begin
         errors++; $display("FAIL rstmid_now: valid=%b dreq.valid=%b stall=%b want 0 0 0", dataE.valid, bus.dreq.valid, mem_stall); end
      tick();
      reset = 1'b0;
      #1;
      checks++; if (bus.dreq.valid !== 1'b0 || dresp_o !== '0) begin
         errors++; $display("FAIL rstmid_after: dreq.valid=%b dresp_o=%h want 0", bus.dreq.valid, dresp_o); end
      load_entry(f);
      dataE_nxt = n;
      bus.dresp = resp(1'b1, 1'b1, 64'h1122_3344_5566_7788);
      #1;
      checks++; if (mem_stall !== 1'b0 || dresp_o.data !== 64'h1122_3344_5566_7788 || bus.dreq.addr !== 64'h8000_0020) begin
         errors++; $display("FAIL rstmid_reload: stall=%b data=%h addr=%h", mem_stall, dresp_o.data, bus.dreq.addr); end
      tick();
      dreq_in   = to_req(n);
      bus.dresp = '0;
      #1;
      checks++; if (dataE !== n) begin errors++; $display("FAIL rstmid_advance: got %h want %h", dataE, n); end
   endtask

   task automatic test_nonmem();
      execute_data_t e;
      for (int i = 0; i < 6; i++) begin
         e         = mk({$urandom, $urandom}, 2'b00, {$urandom, $urandom});
         dataE_nxt = e;
         bus.dresp = resp($urandom_range(0, 1), $urandom_range(0, 1), {$urandom, $urandom});
         #1;
         checks++; if (mem_stall !== 1'b0 || bus.dreq.valid !== 1'b0 || dresp_o !== '0) begin
            errors++; $display("FAIL nonmem_%0d: stall=%b dreq.valid=%b dresp_o=%h want 0", i, mem_stall, bus.dreq.valid, dresp_o); end
         tick();
         dreq_in = to_req(e);
         checks++; if (dataE !== e) begin errors++; $display("FAIL nonmem_adv_%0d: got %h want %h", i, dataE, e); end
      end
   endtask

   // Model: m_wait = address accepted, m_have = data returned but entry not yet moved on.
   task automatic test_random();
      execute_data_t m_entry, nxt;
      logic          m_wait, m_have, m_fp, busy, m_req, done, moves, to_bubble;
      logic          e_stall;
      logic [63:0]   m_held;
      dbus_req_t     e_dreq;
      dbus_resp_t    e_resp;
      reset = 1'b1;
      tick();
      reset   = 1'b0;
      m_entry = '0; m_wait = 1'b0; m_have = 1'b0; m_fp = 1'b0; m_held = '0;
      for (int c = 0; c < 400; c++) begin
         nxt        = mk({$urandom, $urandom}, 2'($urandom_range(0, 2)), 64'h8000_0000 + 64'($urandom & 32'hff8));
         nxt.valid  = ($urandom_range(0, 4) != 0);
         dataE_nxt  = nxt;
         dreq_in    = to_req(m_entry);
         stall_ext  = ($urandom_range(0, 3) == 0);
         flush      = ($urandom_range(0, 9) == 0);
         bus.dresp  = resp($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, {$urandom, $urandom});
         m_req = m_entry.valid && dreq_in.valid;
         busy  = !m_have && (m_req || m_wait);
         if (m_have) begin
            e_dreq = '0; e_resp = resp(1'b0, 1'b1, m_held); e_stall = 1'b0; done = 1'b0;
         end else begin
            e_dreq = busy ? dreq_in : '0;
            if (busy) e_dreq.valid = 1'b1;
            e_resp  = m_req ? bus.dresp : '0;
            done    = busy && bus.dresp.data_ok;
            e_stall = busy && !bus.dresp.data_ok;
         end
         #1;
         checks++; if (dataE !== m_entry) begin errors++; $display("FAIL rnd_dataE_%0d: got %h want %h", c, dataE, m_entry); end
         checks++; if (mem_stall !== e_stall) begin errors++; $display("FAIL rnd_stall_%0d: got %b want %b", c, mem_stall, e_stall); end
         checks++; if (bus.dreq !== e_dreq) begin errors++; $display("FAIL rnd_dreq_%0d: got %h want %h", c, bus.dreq, e_dreq); end
         checks++; if (dresp_o !== e_resp) begin errors++; $display("FAIL rnd_dresp_%0d: got %h want %h", c, dresp_o, e_resp); end
         moves     = !e_stall && (flush || !stall_ext);
         to_bubble = !e_stall && (flush || (m_fp && !stall_ext));
         if (done) m_held = bus.dresp.data;
         m_wait = busy && !done && (m_wait || bus.dresp.addr_ok);
         m_have = (m_have || done) && !moves;
         if (moves) begin
            m_entry = to_bubble ? '0 : nxt;
            m_fp    = 1'b0;
         end else if (flush) m_fp = 1'b1;
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_fast_load();
      test_slow_load();
      test_hold();
      test_flush_wait();
      test_reset_mid();
      test_nonmem();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/memreg.md
MEMREG -- requirements
Module: memreg

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1; asynchronous, active-high.
REQ-003 SHALL have port dataE_nxt, input, execute_data_t, result from the execute stage.
REQ-004 SHALL have port stall_ext, input, 1, stall from other hazard sources; freezes the register.
REQ-005 SHALL have port flush, input, 1, request to replace the memory-stage entry with a bubble.
REQ-006 SHALL have port dataE, output, execute_data_t, registered entry driven to the memory stage.
REQ-007 SHALL have port dreq_in, input, dbus_req_t, combinational request from the memory stage.
REQ-008 SHALL have port dreq, output, dbus_req_t, request to the data bus.
REQ-009 SHALL have port dresp, input, dbus_resp_t, bus response with addr_ok, data_ok and data.
REQ-010 SHALL have port dresp_o, output, dbus_resp_t, response forwarded to the memory stage.
REQ-011 SHALL have port mem_stall, output, 1, high while a bus access is outstanding.

Function
REQ-012 SHALL implement the FSM states IDLE, WAIT_DATA and HOLD.
REQ-013 SHALL define req as dataE.valid && dreq_in.valid.
REQ-014 IDLE: dreq = dreq_in when req, else '0.
REQ-015 IDLE transitions: req && data_ok -> complete; req && addr_ok && !data_ok -> WAIT_DATA; req with neither -> stay in IDLE with the request held.
REQ-016 WAIT_DATA: dreq = dreq_in with valid=1; stay until data_ok.
REQ-017 dreq SHALL be held stable from first assertion until data_ok, and an access SHALL never be issued twice.
REQ-018 On completion: dresp_o.data = dresp.data combinationally in the data_ok cycle (zero added latency). Next state: HOLD if stall_ext, else IDLE.
REQ-019 Data SHALL be captured into a held register on completion.
REQ-020 HOLD: dreq.valid=0; dresp_o = {data_ok=1, data=held}; exit to IDLE on the first cycle the register advances or a flush occurs.
REQ-021 SHALL drive mem_stall = (IDLE && req && !data_ok) || (WAIT_DATA && !data_ok); mem_stall is combinational.
REQ-022 SHALL advance (load dataE_nxt) only when !mem_stall && !stall_ext; otherwise dataE SHALL hold.
REQ-023 flush && !mem_stall SHALL load a bubble (all fields '0, valid=0), overriding stall_ext.
REQ-024 flush while mem_stall SHALL set flush_pending; the in-flight access completes normally. flush_pending then forces a bubble load at the next advance and clears.
REQ-025 A non-memory or invalid entry (req=0) SHALL never assert mem_stall or dreq.valid.
REQ-026 Outside HOLD and completion, dresp_o SHALL pass dresp through, gated to '0 when req=0.

Reset
REQ-027 reset SHALL force state=IDLE, dataE='0 (valid=0), held data=0 and flush_pending=0.
REQ-028 During and immediately after reset, dreq.valid=0, mem_stall=0 and dresp_o='0.
REQ-029 reset mid-transaction SHALL abandon the access; the first post-reset cycle SHALL have dreq.valid=0.

Structure
REQ-030 The FSM state enum (memreg_state_t) SHALL be declared in package pipes; execute_data_t, dbus_req_t and dbus_resp_t SHALL be reused from pipes and common.
REQ-031 SHALL be a single module with no sub-modules; its dataE output connects directly to the memory stage input.

Verification
REQ-032 Load at 0x80000010 with addr_ok=data_ok=1 in the same cycle -> mem_stall=0, dresp_o.data=0x1122334455667788 that cycle, next entry loads next cycle.
REQ-033 Load with addr_ok at cycle 1 and data_ok at cycle 4 -> mem_stall high for cycles 0-3, dreq stable throughout, a single access, advance at cycle 4.
REQ-034 data_ok while stall_ext=1 for 3 cycles -> state HOLD, dreq.valid=0, dresp_o.data held constant, no reissue, advance when stall_ext falls.
REQ-035 flush asserted during WAIT_DATA -> access completes, then a bubble (valid=0) is loaded and flush_pending clears.
REQ-036 reset pulsed in WAIT_DATA -> dataE.valid=0 and dreq.valid=0 immediately; a later load at 0x80000020 behaves per REQ-032.
REQ-037 Non-memory entry (memRw=2'b00) with dreq_in.valid=0 -> mem_stall=0, dreq.valid=0, advance every cycle.
